// File: rtl/int_to_float_pkg.sv
// Shared types for the integer-to-float pipeline: input mode, stage control word, output width helper.
package int_to_float_pkg;

  typedef enum logic {
    MODE_SIGN_MAG = 1'b0,
    MODE_TWOS     = 1'b1
  } mode_e;

  // Control fields carried alongside every pipeline stage.
  typedef struct packed {
    logic  vld;
    logic  sign;
    mode_e mode;
  } stage_ctl_t;

  function automatic int y_width(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

endpackage

// File: rtl/int_to_float_pipe_if.sv
// Sample-in / float-out handshake bundle; master is the source+sink side, slave is the converter.
interface int_to_float_pipe_if #(
  parameter int IN_W   = 8,
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
);
  import int_to_float_pkg::*;

  logic                                  in_valid;
  logic                                  in_ready;
  logic [IN_W-1:0]                       in_data;
  mode_e                                 in_mode;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [y_width(EXP_W, FRAC_W)-1:0]     out_y;
  logic                                  out_inexact;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_y, out_inexact
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_y, out_inexact
  );

endinterface

// File: rtl/int_to_float_pipe_lzc.sv
// Leading-zero counter, combinational; all-zero input returns W.
module lzc #(
  parameter int W = 8
) (
  input  logic [W-1:0]             i_dat,
  output logic [$clog2(W+1)-1:0]   o_cnt
);
  localparam int CW = $clog2(W+1);

  // Ascending scan: the highest set bit is the last to overwrite the count.
  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_dat[i]) o_cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/int_to_float_pipe.sv
// Integer to {sign, exp, frac} converter with round-to-nearest-even; 3-cycle latency, 1 sample/cycle.
// Whole pipeline stalls while the output stage holds an unaccepted result; bubbles are kept.
module int_to_float_pipe #(
  parameter int IN_W   = 8,
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  int_to_float_pipe_if.slave   bus
);
  import int_to_float_pkg::*;

  localparam int Y_W   = y_width(EXP_W, FRAC_W);
  localparam int LZ_W  = $clog2(IN_W + 1);
  localparam int EXT_W = IN_W + FRAC_W + 2;

  if ((2 ** EXP_W) - 1 < IN_W) begin : g_bad_exp_w
    $error("EXP_W too small to encode exponent IN_W");
  end

  typedef struct packed {
    stage_ctl_t      ctl;
    logic [IN_W-1:0] mag;
  } s1_t;

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [EXP_W-1:0] exp;
    logic [IN_W-1:0]  norm;
  } s2_t;

  s1_t              r_s1, w_s1_nxt;
  s2_t              r_s2, w_s2_nxt;
  logic             r_s3_vld;
  logic [Y_W-1:0]   r_y;
  logic             r_inexact;

  logic             w_en;
  logic [LZ_W-1:0]  w_lz;
  logic [EXT_W-1:0] w_ext;
  logic [FRAC_W-1:0] w_kept;
  logic             w_guard, w_sticky, w_sign3;
  logic [FRAC_W:0]  w_rnd;
  logic [FRAC_W-1:0] w_frac;
  logic [EXP_W-1:0] w_exp3;

  assign w_en          = !r_s3_vld | bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_s3_vld;
  assign bus.out_y     = r_y;
  assign bus.out_inexact = r_inexact;

  // S1: sign and magnitude; two's complement min value maps to 2^(IN_W-1).
  always_comb begin
    w_s1_nxt.ctl.vld  = bus.in_valid;
    w_s1_nxt.ctl.sign = bus.in_data[IN_W-1];
    w_s1_nxt.ctl.mode = bus.in_mode;
    if (bus.in_mode == MODE_TWOS)
      w_s1_nxt.mag = bus.in_data[IN_W-1] ? -bus.in_data : bus.in_data;
    else
      w_s1_nxt.mag = {1'b0, bus.in_data[IN_W-2:0]};
  end

  lzc #(.W(IN_W)) u_lzc (
    .i_dat (r_s1.mag),
    .o_cnt (w_lz)
  );

  // S2: normalise; a zero magnitude yields lz = IN_W and hence exp = 0.
  always_comb begin
    w_s2_nxt.ctl  = r_s1.ctl;
    w_s2_nxt.exp  = EXP_W'(IN_W) - EXP_W'(w_lz);
    w_s2_nxt.norm = r_s1.mag << w_lz;
  end

  // S3: pad below norm so guard/sticky are simply zero when FRAC_W >= IN_W.
  always_comb begin
    w_ext    = {r_s2.norm, {(FRAC_W+2){1'b0}}};
    w_kept   = w_ext[EXT_W-1 -: FRAC_W];
    w_guard  = w_ext[EXT_W-1-FRAC_W];
    w_sticky = |w_ext[EXT_W-2-FRAC_W:0];
    w_rnd    = {1'b0, w_kept} + {{FRAC_W{1'b0}}, w_guard & (w_sticky | w_kept[0])};
    w_frac   = w_rnd[FRAC_W] ? w_rnd[FRAC_W:1] : w_rnd[FRAC_W-1:0];
    w_exp3   = r_s2.exp + EXP_W'(w_rnd[FRAC_W]);
    w_sign3  = r_s2.ctl.sign & !((r_s2.ctl.mode == MODE_TWOS) && (r_s2.norm == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3_vld  <= 1'b0;
      r_y       <= '0;
      r_inexact <= 1'b0;
    end else if (w_en) begin
      r_s1      <= w_s1_nxt;
      r_s2      <= w_s2_nxt;
      r_s3_vld  <= r_s2.ctl.vld;
      r_y       <= {w_sign3, w_exp3, w_frac};
      r_inexact <= w_guard | w_sticky;
    end
  end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Scoreboard bench: default 8/4/8 instance plus a 16/5/8 instance for rounding cases.
module tb_int_to_float_pipe;
  import int_to_float_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int_to_float_pipe_if #(.IN_W(8),  .EXP_W(4), .FRAC_W(8)) ifa();
  int_to_float_pipe_if #(.IN_W(16), .EXP_W(5), .FRAC_W(8)) ifb();

  int_to_float_pipe #(.IN_W(8),  .EXP_W(4), .FRAC_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  int_to_float_pipe #(.IN_W(16), .EXP_W(5), .FRAC_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int checks = 0;
  int errors = 0;
  int n_out_a = 0;
  int n_out_b = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  bit drv_done;

  // expected words are {inexact, out_y}: A uses bits 13:0, B uses 14:0
  logic [7:0]  va_d [12] = '{8'h45, 8'h85, 8'h80, 8'hFB, 8'h80, 8'h00, 8'h00, 8'h7F, 8'h01, 8'hFF, 8'hFF, 8'h45};
  bit          va_m [12] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
  logic [15:0] va_e [12] = '{16'h078A, 16'h13A0, 16'h1880, 16'h13A0, 16'h1000, 16'h0000,
                             16'h0000, 16'h07FE, 16'h0180, 16'h17FE, 16'h1180, 16'h078A};
  logic [15:0] vb_d [7]  = '{16'h01FF, 16'h0181, 16'h0180, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000};
  bit          vb_m [7]  = '{1, 1, 1, 1, 1, 1, 0};
  logic [15:0] vb_e [7]  = '{16'h4A80, 16'h49C0, 16'h09C0, 16'h2180, 16'h3080, 16'h5080, 16'h2000};
  logic [7:0]  bp_d [6]  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
  logic [15:0] bp_e [6]  = '{16'h0180, 16'h0280, 16'h02C0, 16'h0380, 16'h03A0, 16'h03C0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: frac = mag * 2^FRAC_W / 2^exp, nearest-even on the remainder.
  function automatic logic [15:0] ref_cvt(input longint unsigned d, input bit twos,
                                          input int in_w, input int ew, input int fw);
    longint unsigned mag, num, frac, rem, half, y;
    int  e;
    bit  msb, sgn, inex;
    d    = d & ((64'd1 << in_w) - 1);
    msb  = d[in_w-1];
    if (twos) mag = msb ? ((64'd1 << in_w) - d) : d;
    else      mag = d & ((64'd1 << (in_w-1)) - 1);
    sgn = msb;
    if (mag == 0) begin
      if (twos) sgn = 1'b0;
      return 16'((64'(sgn)) << (ew + fw));
    end
    e = 0;
    for (int b = 0; b < in_w; b++) if (mag[b]) e = b + 1;
    num  = mag << fw;
    frac = num >> e;
    rem  = num - (frac << e);
    half = 64'd1 << (e - 1);
    if (rem > half || (rem == half && frac[0])) frac++;
    inex = (rem != 0);
    if (frac == (64'd1 << fw)) begin
      frac = 64'd1 << (fw - 1);
      e++;
    end
    y = (64'(sgn) << (ew + fw)) | (64'(e) << fw) | frac | (64'(inex) << (1 + ew + fw));
    return 16'(y);
  endfunction

  task automatic send_a(input logic [7:0] d, input bit m, input logic [15:0] e, input bit push);
    bit ok = 0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    ifa.in_mode  = mode_e'(m);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ifa.in_ready) begin ok = 1; break; end
    end
    check("a_accept", 64'(ok), 64'd1);
    if (ok && push) q_a.push_back(e);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input bit m, input logic [15:0] e);
    bit ok = 0;
    ifb.in_valid = 1'b1;
    ifb.in_data  = d;
    ifb.in_mode  = mode_e'(m);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ifb.in_ready) begin ok = 1; break; end
    end
    check("b_accept", 64'(ok), 64'd1);
    if (ok) q_b.push_back(e);
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
  endtask

  task automatic check_latency_a(input string name);
    int lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ifa.out_valid) begin lat = i; break; end
    end
    check(name, 64'(lat), 64'd3);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    check(name, 64'(q_a.size() + q_b.size()), 64'd0);
  endtask

  initial begin : mon_a
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ifa.out_valid && ifa.out_ready) begin
        n_out_a++;
        if (q_a.size() == 0) check("a_unexpected_out", 64'({ifa.out_inexact, ifa.out_y}), 64'hDEAD);
        else begin
          e = q_a.pop_front();
          check("a_out", 64'({ifa.out_inexact, ifa.out_y}), 64'(e));
        end
      end
    end
  end

  initial begin : mon_b
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ifb.out_valid && ifb.out_ready) begin
        n_out_b++;
        if (q_b.size() == 0) check("b_unexpected_out", 64'({ifb.out_inexact, ifb.out_y}), 64'hDEAD);
        else begin
          e = q_b.pop_front();
          check("b_out", 64'({ifb.out_inexact, ifb.out_y}), 64'(e));
        end
      end
    end
  end

  initial begin : stim
    int k, base;
    rst_n = 1'b0;
    ifa.in_valid = 0; ifa.in_data = '0; ifa.in_mode = MODE_SIGN_MAG; ifa.out_ready = 1;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.in_mode = MODE_SIGN_MAG; ifb.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    check("rst_out_y", 64'(ifa.out_y), 64'd0);
    check("rst_inexact", 64'(ifa.out_inexact), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready_a", 64'(ifa.in_ready), 64'd1);
    check("rst_in_ready_b", 64'(ifb.in_ready), 64'd1);

    // first-sample latency
    @(posedge clk); #1;
    send_a(va_d[0], va_m[0], va_e[0], 1);
    check_latency_a("a_latency");
    drain("drain_latency");

    @(posedge clk); #1;
    for (int i = 1; i < 12; i++) send_a(va_d[i], va_m[i], va_e[i], 1);
    for (int i = 0; i < 7; i++) send_b(vb_d[i], vb_m[i], vb_e[i]);
    drain("drain_directed");

    // backpressure: sink stalled while 1..6 stream in
    @(posedge clk); #1;
    base = n_out_a;
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_mode   = MODE_SIGN_MAG;
    k = 0;
    ifa.in_data = bp_d[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        check("bp_hold_vld", 64'(ifa.out_valid), 64'd1);
        check("bp_hold_y", 64'({ifa.out_inexact, ifa.out_y}), 64'h0180);
      end
      if (ifa.in_ready) begin q_a.push_back(bp_e[k]); k++; end
      @(posedge clk); #1;
      ifa.in_data = bp_d[k];
    end
    ifa.in_valid = 1'b0;
    check("bp_accepts", 64'(k), 64'd3);
    check("bp_in_ready_low", 64'(ifa.in_ready), 64'd0);
    ifa.out_ready = 1'b1;
    for (int i = k; i < 6; i++) send_a(bp_d[i], 0, bp_e[i], 1);
    drain("drain_bp");
    check("bp_out_count", 64'(n_out_a - base), 64'd6);

    // reset with three samples in flight
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_a(8'h11, 0, 16'h0, 0);
    #2 rst_n = 1'b0;
    #1 check("rst_async_vld", 64'(ifa.out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_stale", 64'(ifa.out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send_a(8'h45, 0, 16'h078A, 1);
    check_latency_a("rst_latency");
    drain("drain_rst");

    // random valid/ready against the arithmetic reference
    drv_done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [7:0] d;
          bit m;
          d = 8'($urandom_range(0, 255));
          m = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_a(d, m, ref_cvt(64'(d), m, 8, 4, 8), 1);
        end
        drv_done = 1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          ifa.out_ready = ($urandom_range(0, 3) != 0);
        end
        ifa.out_ready = 1'b1;
      end
    join
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
